fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction fetch queue between the instruction cache output and the decode stage.
- Accepts one {pc, instruction} pair per cycle whenever the cache reports a hit.
- Buffers up to DEPTH entries so decode stalls do not stall fetch immediately.
- Presents entries in order to decode over a valid/ready handshake.
- Supports a single-cycle flush on branch redirect or mispredict recovery.

Parameters:
DEPTH, 4, number of entries; power of two, ≥2; elaboration error otherwise.
PC_WIDTH, 26, width of stored PC (byte address).
INSTR_WIDTH, 32, width of stored instruction word.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
flush  in  1  discard all entries and any same-cycle push
in_valid  in  1  cache hit: in_pc/in_instr are valid this cycle
in_pc  in  PC_WIDTH  PC of incoming instruction
in_instr  in  INSTR_WIDTH  incoming instruction word
in_ready  out  1  queue can accept a push this cycle
out_valid  out  1  head entry valid
out_pc  out  PC_WIDTH  PC of head entry
out_instr  out  INSTR_WIDTH  instruction of head entry
out_ready  in  1  decode consumes head this cycle
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
Storage and pointers
- Storage is a register array of DEPTH × (PC_WIDTH+INSTR_WIDTH).
- Read pointer and write pointer are each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- empty = pointers equal. full = indices equal and wrap bits differ.
- count = wr_ptr − rd_ptr, modulo 2^($clog2(DEPTH)+1).

Handshake
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- in_ready = ~full. It depends only on registered state; there is no combinational path from out_ready.
- out_valid = ~empty. out_pc/out_instr are driven combinationally from storage[rd_ptr index].
- When out_valid = 0, out_pc/out_instr are don't-care; the bench must not check them.

Latency
- Base build: a pushed entry becomes visible at the output the cycle after the push (1-cycle latency).

Simultaneous events
- Push and pop in the same cycle: both pointers advance; count unchanged.
- When full, in_ready = 0 even if out_ready = 1. Max throughput when full is one push per cycle, starting one cycle after a pop frees a slot.
- Pop when empty is ignored (out_valid = 0).
- Push when full is ignored (in_ready = 0). The upstream cache must hold its output, which the cache's pc_current/pc_next stall path already does.

Flush
- On a cycle with flush = 1, both pointers are set to 0 at the next clock edge, so count = 0 and out_valid = 0 the following cycle.
- The same-cycle push is dropped and the same-cycle pop is suppressed.
- Flush has priority over all other events.
- in_ready is unaffected by flush within the cycle.

Wrap-around
- Index bits wrap modulo DEPTH. The wrap bit toggles at each wrap, so full and empty stay distinguishable.

Reset
- rst_n = 0 at a clock edge sets rd_ptr = wr_ptr = 0.
- Resulting outputs: out_valid = 0, in_ready = 1, count = 0.
- Storage contents are not reset.
- Reset mid-operation discards all entries exactly as flush does.

Optional Feature:
Macro FETCH_QUEUE_BYPASS_EN.
- Defined: fall-through bypass.
  - When the queue is empty and in_valid = 1 and flush = 0, out_valid = 1 combinationally, with out_pc/out_instr = in_pc/in_instr in the same cycle.
  - If out_ready = 1 in that cycle, the entry is consumed directly and not written. Pointers and count are unchanged.
  - If out_ready = 0, the entry is written as a normal push.
  - Zero-cycle latency when empty.
  - Adds a combinational path from in_valid/in_pc/in_instr to the out_* ports.
- Undefined: no bypass. Output comes from storage only, with 1-cycle latency as specified above.

Test Plan:
1. Reset then idle. Expect out_valid = 0, in_ready = 1, count = 0 for 5 cycles after rst_n rises.
2. Fill with out_ready = 0: push PC 0x000000, 0x000004, 0x000008, 0x00000C. Expect count = 4 and in_ready = 0. A fifth push of 0x000010 is dropped.
3. Drain the full queue from test 2 with out_ready = 1. Expect outputs 0x000000, 0x000004, 0x000008, 0x00000C on consecutive cycles, then out_valid = 0 and count = 0.
4. Streaming with in_valid = out_ready = 1 for 20 cycles, PCs incrementing by 4. Expect count steady at 1 (base build) and in-order output with no gaps.
5. Wrap-around: 3 pushes, 3 pops, then 4 pushes. Expect count = 4, full asserted, output order preserved across the index wrap.
6. Flush with count = 3 and a simultaneous push of PC 0x000100. Next cycle expect count = 0 and out_valid = 0; PC 0x000100 never appears. With FETCH_QUEUE_BYPASS_EN, a push when empty with out_ready = 1 shows out_valid = 1 the same cycle while count stays 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the I-cache and decode: in-order valid/ready FIFO with single-cycle flush.
// Optional fall-through bypass when empty is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH       = 4,
  parameter int PC_WIDTH    = 26,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [PC_WIDTH-1:0]      in_pc,
  input  logic [INSTR_WIDTH-1:0]   in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [PC_WIDTH-1:0]      out_pc,
  output logic [INSTR_WIDTH-1:0]   out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = PC_WIDTH + INSTR_WIDTH;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fetch_queue: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [EW-1:0] storage [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  assign empty    = (rd_ptr == wr_ptr);
  assign full     = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
  assign in_ready = ~full;
  assign count    = wr_ptr - rd_ptr;
  assign head     = storage[rd_ptr[AW-1:0]];

`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue forwards the incoming entry straight to decode; it is only
  // written when decode cannot take it this cycle.
  logic bypass;
  assign bypass    = empty & in_valid & ~flush;
  assign out_valid = ~empty | bypass;
  assign {out_pc, out_instr} = bypass ? {in_pc, in_instr} : head;
  assign pop       = ~empty & out_ready & ~flush;
  assign push      = in_valid & in_ready & ~flush & ~(bypass & out_ready);
`else
  assign out_valid = ~empty;
  assign {out_pc, out_instr} = head;
  assign pop       = out_valid & out_ready & ~flush;
  assign push      = in_valid & in_ready & ~flush;
`endif

  // Contents are deliberately left unreset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      storage[wr_ptr[AW-1:0]] <= {in_pc, in_instr};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed test-plan steps followed by random traffic,
// checked against a queue-based reference model (bypass-aware when FETCH_QUEUE_BYPASS_EN is set).
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PCW   = 26;
  localparam int IW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic [PCW-1:0]  in_pc;
  logic [IW-1:0]   in_instr;
  logic            in_ready;
  logic            out_valid;
  logic [PCW-1:0]  out_pc;
  logic [IW-1:0]   out_instr;
  logic            out_ready;
  logic [CW-1:0]   count;

  int vectors     = 0;
  int miscompares = 0;

  logic [PCW+IW-1:0] model_q[$];

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(PCW), .INSTR_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
    .count(count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, then advance the model at posedge.
  task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                               input logic [PCW-1:0] pc, input logic ordy);
    int  n;
    bit  exp_valid;
    bit  byp_now;
    logic [PCW+IW-1:0] exp_data;
    @(negedge clk);
    rst_n     = rst;
    flush     = fl;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = $urandom;
    out_ready = ordy;
    #1;
    n         = model_q.size();
    byp_now   = BYP && (n == 0) && iv && !fl;
    exp_valid = (n > 0) || byp_now;
    exp_data  = byp_now ? {pc, in_instr} : ((n > 0) ? model_q[0] : '0);
    checkOutput("count", 64'(count), 64'(n));
    checkOutput("in_ready", 64'(in_ready), 64'(n < DEPTH));
    checkOutput("out_valid", 64'(out_valid), 64'(exp_valid));
    if (exp_valid) checkOutput("out_data", 64'({out_pc, out_instr}), 64'(exp_data));
    @(posedge clk);
    if (!rst || fl) begin
      model_q.delete();
    end else if (!(byp_now && ordy)) begin
      if (n > 0 && ordy) void'(model_q.pop_front());
      if (iv && n < DEPTH) model_q.push_back({pc, in_instr});
    end
  endtask

  initial begin
    logic [PCW-1:0] pc;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_q.delete();

    // Reset then idle
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, '0, 0);

    // Fill to full; the fifth push must be dropped
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, PCW'(4 * i), 0);
    applyStimulus(1, 0, 0, '0, 0);

    // Drain in order
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, '0, 1);

    // Streaming
    pc = PCW'('h200);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 1, pc, 1);
      pc += 4;
    end
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, '0, 1);

    // Wrap-around: 3 pushes, 3 pops, 4 pushes, then drain
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, PCW'('h300 + 4 * i), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, '0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, PCW'('h400 + 4 * i), 0);
    applyStimulus(1, 0, 1, PCW'('h410), 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, '0, 1);

    // Flush with count 3 and a simultaneous push of 0x100
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, PCW'('h500 + 4 * i), 0);
    applyStimulus(1, 1, 1, PCW'('h100), 1);
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, '0, 1);

    // Push into an empty queue with decode ready (same-cycle forwarding with bypass)
    applyStimulus(1, 0, 1, PCW'('h600), 1);
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, '0, 1);

    // Reset mid-operation discards entries
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 1, PCW'('h700 + 4 * i), 0);
    applyStimulus(0, 0, 1, PCW'('h708), 0);
    applyStimulus(1, 0, 0, '0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 29) == 0),
                    $urandom_range(0, 1), PCW'($urandom), $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
